// File: rtl/arith_pkg.sv
// Shared types and constants for the time-shared (x1 + x3) * x2 sequencer.
package arith_pkg;

    localparam int unsigned DEF_W = 8;
    localparam int unsigned N_REQ = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUM  = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage : arith_pkg

// File: rtl/cla_adder_w.sv
// W-bit carry-lookahead adder built from a parallel-prefix (Kogge-Stone) carry network.
module cla_adder_w import arith_pkg::*; #(
    parameter int unsigned W = DEF_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W-1:0] p0;
    logic [W-1:0] gg;
    logic [W-1:0] pp;
    logic [W-1:0] ng;
    logic [W-1:0] np;
    logic [W:0]   c;

    // Prefix tree of group generate/propagate, then carries from cin.
    always_comb begin
        p0 = a ^ b;
        gg = a & b;
        pp = p0;
        ng = '0;
        np = '0;
        c  = '0;
        for (int d = 1; d < int'(W); d = d * 2) begin
            ng = gg;
            np = pp;
            for (int i = 0; i < int'(W); i++) begin
                if (i >= d) begin
                    ng[i] = gg[i] | (pp[i] & gg[i-d]);
                    np[i] = pp[i] & pp[i-d];
                end
            end
            gg = ng;
            pp = np;
        end
        c[0] = cin;
        for (int i = 0; i < int'(W); i++) begin
            c[i+1] = gg[i] | (pp[i] & cin);
        end
    end

    assign sum  = p0 ^ c[W-1:0];
    assign cout = c[W];

endmodule : cla_adder_w

// File: rtl/arith_seq_ctrl.sv
// Round-robin sequencer computing y = (x1 + x3) * x2 mod 2^W on one shared adder.
module arith_seq_ctrl import arith_pkg::*; #(
    parameter int unsigned W = DEF_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*W-1:0] req_x1,
    input  logic [N_REQ*W-1:0] req_x2,
    input  logic [N_REQ*W-1:0] req_x3,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       out_y,
    output logic               out_id,
    output logic               busy
);

    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    state_e          state_q, state_d;
    logic            ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    x1_q, x1_d;
    logic [W-1:0]    x2_q, x2_d;
    logic [W-1:0]    x3_q, x3_d;
    logic [W-1:0]    s_q, s_d;
    logic [W-1:0]    acc_q, acc_d;
    logic            id_q, id_d;
    logic [W-1:0]    out_y_q, out_y_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q, busy_d;

    logic            any_req_c;
    logic            grant_c;
    logic [W-1:0]    add_a_c;
    logic [W-1:0]    add_b_c;
    logic [W-1:0]    add_sum_c;
    logic            add_cout_c;
    logic            unused_cout_c;

    // Round-robin pick: on contention favour the requester not granted last.
    always_comb begin
        any_req_c = |req_valid;
        if (req_valid == 2'b11) begin
            grant_c = ~ptr_q;
        end else begin
            grant_c = req_valid[1];
        end
        req_ready = '0;
        if (state_q == IDLE && any_req_c) begin
            req_ready[grant_c] = 1'b1;
        end
    end

    // Adder operands: pre-sum in SUM, gated shifted partial product in MUL.
    always_comb begin
        add_a_c = '0;
        add_b_c = '0;
        case (state_q)
            SUM: begin
                add_a_c = x1_q;
                add_b_c = x3_q;
            end
            MUL: begin
                add_a_c = acc_q;
                add_b_c = x2_q[cnt_q] ? (s_q << cnt_q) : '0;
            end
            default: ;
        endcase
    end

    cla_adder_w #(.W(W)) u_adder (
        .a    (add_a_c),
        .b    (add_b_c),
        .cin  (1'b0),
        .sum  (add_sum_c),
        .cout (add_cout_c)
    );

    // Carry-out of the modular arithmetic is intentionally dropped.
    assign unused_cout_c = add_cout_c;

    // Next-state and datapath register updates.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        x1_d        = x1_q;
        x2_d        = x2_q;
        x3_d        = x3_q;
        s_d         = s_q;
        acc_d       = acc_q;
        id_d        = id_q;
        out_y_d     = out_y_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (any_req_c) begin
                    state_d = SUM;
                    ptr_d   = grant_c;
                    id_d    = grant_c;
                    x1_d    = grant_c ? req_x1[2*W-1:W] : req_x1[W-1:0];
                    x2_d    = grant_c ? req_x2[2*W-1:W] : req_x2[W-1:0];
                    x3_d    = grant_c ? req_x3[2*W-1:W] : req_x3[W-1:0];
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            SUM: begin
                s_d     = add_sum_c;
                cnt_d   = '0;
                state_d = MUL;
            end
            MUL: begin
                acc_d = add_sum_c;
                if (cnt_q == CW'(W - 1)) begin
                    state_d     = DONE;
                    out_y_d     = add_sum_c;
                    out_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and datapath registers with asynchronous abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b1;
            cnt_q       <= '0;
            x1_q        <= '0;
            x2_q        <= '0;
            x3_q        <= '0;
            s_q         <= '0;
            acc_q       <= '0;
            id_q        <= 1'b0;
            out_y_q     <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            x1_q        <= x1_d;
            x2_q        <= x2_d;
            x3_q        <= x3_d;
            s_q         <= s_d;
            acc_q       <= acc_d;
            id_q        <= id_d;
            out_y_q     <= out_y_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_y     = out_y_q;
    assign out_id    = id_q;
    assign busy      = busy_q;

endmodule : arith_seq_ctrl

// File: tb/tb_arith_seq_ctrl.sv
// Directed self-checking bench for arith_seq_ctrl.
module tb_arith_seq_ctrl;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [2*W-1:0] req_x1;
    logic [2*W-1:0] req_x2;
    logic [2*W-1:0] req_x3;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_y;
    logic           out_id;
    logic           busy;

    int vec_cnt = 0;
    int err_cnt = 0;

    arith_seq_ctrl #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x1    (req_x1),
        .req_x2    (req_x2),
        .req_x3    (req_x3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_id    (out_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Present operands for requester i and raise its valid.
    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] c);
        if (i == 0) begin
            req_x1[W-1:0] = a;
            req_x2[W-1:0] = b;
            req_x3[W-1:0] = c;
            req_valid[0]  = 1'b1;
        end else begin
            req_x1[2*W-1:W] = a;
            req_x2[2*W-1:W] = b;
            req_x3[2*W-1:W] = c;
            req_valid[1]    = 1'b1;
        end
    endtask

    // One full transaction with out_ready high; entered at a negedge in IDLE.
    task automatic serve(input int gi, input logic [W-1:0] exp_y, input string tag);
        logic [1:0] exp_rdy;
        int lat;
        exp_rdy = (gi == 0) ? 2'b01 : 2'b10;
        #1;
        vec_cnt++;
        if (req_ready !== exp_rdy) begin
            err_cnt++;
            $display("FAIL %s grant: req_ready=%b expected=%b", tag, req_ready, exp_rdy);
        end
        @(posedge clk);
        #1 req_valid[gi] = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            vec_cnt++;
            if (req_ready !== 2'b00) begin
                err_cnt++;
                $display("FAIL %s ready_while_busy: req_ready=%b expected=00", tag, req_ready);
            end
            if (out_valid === 1'b1) break;
        end
        vec_cnt++;
        if (lat != W + 1) begin
            err_cnt++;
            $display("FAIL %s latency: got=%0d expected=%0d", tag, lat, W + 1);
        end
        vec_cnt++;
        if (out_y !== exp_y) begin
            err_cnt++;
            $display("FAIL %s out_y: got=%0d expected=%0d", tag, out_y, exp_y);
        end
        vec_cnt++;
        if (out_id !== gi[0]) begin
            err_cnt++;
            $display("FAIL %s out_id: got=%b expected=%b", tag, out_id, gi[0]);
        end
        @(posedge clk);
        @(negedge clk);
        vec_cnt++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL %s consume: out_valid=%b busy=%b expected 0 0", tag, out_valid, busy);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        vec_cnt++;
        if (req_ready !== 2'b00 || out_valid !== 1'b0 || out_y !== '0 ||
            out_id !== 1'b0 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_state: ready=%b valid=%b y=%0d id=%b busy=%b expected all 0",
                     req_ready, out_valid, out_y, out_id, busy);
        end
        rst = 1'b0;
    endtask

    task automatic test_contention();
        set_req(0, 8'd1, 8'd2, 8'd3);
        set_req(1, 8'd10, 8'd11, 8'd5);
        serve(0, 8'd8, "contend_first");
        serve(1, 8'd165, "contend_second");
        set_req(0, 8'd3, 8'd3, 8'd3);
        set_req(1, 8'd2, 8'd2, 8'd2);
        serve(0, 8'd18, "contend_third");
        serve(1, 8'd8, "contend_fourth");
    endtask

    task automatic test_basic();
        set_req(0, 8'd4, 8'd5, 8'd2);
        serve(0, 8'd30, "basic_r0");
        set_req(1, 8'd0, 8'd0, 8'd0);
        serve(1, 8'd0, "zero_r1");
    endtask

    task automatic test_wrap();
        set_req(0, 8'd200, 8'd3, 8'd100);
        serve(0, 8'd132, "wrap_sum");
        set_req(0, 8'd16, 8'd17, 8'd0);
        serve(0, 8'd16, "wrap_product");
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready = 1'b0;
        set_req(0, 8'd7, 8'd9, 8'd3);
        #1;
        vec_cnt++;
        if (req_ready !== 2'b01) begin
            err_cnt++;
            $display("FAIL bp_grant: req_ready=%b expected=01", req_ready);
        end
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        set_req(1, 8'd1, 8'd2, 8'd3);
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid === 1'b1) break;
        end
        vec_cnt++;
        if (lat != W + 1) begin
            err_cnt++;
            $display("FAIL bp_latency: got=%0d expected=%0d", lat, W + 1);
        end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            vec_cnt++;
            if (out_valid !== 1'b1 || out_y !== 8'd90 || out_id !== 1'b0 ||
                req_ready !== 2'b00 || busy !== 1'b1) begin
                err_cnt++;
                $display("FAIL bp_hold%0d: valid=%b y=%0d id=%b ready=%b busy=%b expected 1 90 0 00 1",
                         k, out_valid, out_y, out_id, req_ready, busy);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vec_cnt++;
        if (out_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL bp_consume: out_valid=%b expected=0", out_valid);
        end
        serve(1, 8'd8, "bp_pending_r1");
    endtask

    task automatic test_reset_mid();
        set_req(0, 8'd9, 8'd9, 8'd9);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        vec_cnt++;
        if (busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL mid_busy: busy=%b expected=1", busy);
        end
        rst = 1'b1;
        #1;
        vec_cnt++;
        if (req_ready !== 2'b00 || out_valid !== 1'b0 || out_y !== '0 ||
            out_id !== 1'b0 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL mid_reset: ready=%b valid=%b y=%0d id=%b busy=%b expected all 0",
                     req_ready, out_valid, out_y, out_id, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        set_req(0, 8'd4, 8'd5, 8'd2);
        serve(0, 8'd30, "after_reset");
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_x1    = '0;
        req_x2    = '0;
        req_x3    = '0;
        out_ready = 1'b1;
        test_reset();
        test_contention();
        test_basic();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, vectors=%0d", vec_cnt);
        $fatal(1);
    end

endmodule : tb_arith_seq_ctrl

// File: doc/arith_seq_ctrl.md
# arith_seq_ctrl

Multi-cycle sequencer and arbiter for the shared 8-bit arithmetic datapath computing y = (x1 + x3) * x2, modulo 2^W. Two requesters compete for one carry-lookahead adder, which is reused for the pre-sum and for every shift-add partial product. The block sits between requester front-ends and result consumers. It replaces replicated combinational arithmetic trees with a single time-shared adder.

## Interface
Parameters:
- W, default 8: operand and result width.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous, active-high reset.
- req_valid, input, 2: bit i means requester i presents operands.
- req_ready, output, 2: bit i is high in the cycle requester i's operands are accepted. One-hot or zero.
- req_x1, input, 2*W: operand x1. Requester i uses bits [i*W +: W]. Same packing for req_x2 and req_x3.
- req_x2, input, 2*W: operand x2 (multiplier).
- req_x3, input, 2*W: operand x3.
- out_valid, output, 1: result available.
- out_ready, input, 1: consumer accepts result.
- out_y, output, W: result, ((x1 + x3) mod 2^W) * x2 mod 2^W.
- out_id, output, 1: index of the requester that owns out_y.
- busy, output, 1: high in any state other than IDLE.

## Operation
- FSM states:
  - IDLE: waiting for requests.
  - SUM: computes and registers s = x1 + x3 through the adder. Carry-out is discarded.
  - MUL: eight iterations. Iteration i (0..W-1) sets acc = acc + (x2[i] ? s << i : 0) through the same adder, truncated to W bits.
  - DONE: holds out_valid until the result is consumed.
- Transitions:
  - IDLE -> SUM when any req_valid bit is set.
  - SUM -> MUL unconditionally.
  - MUL -> DONE after iteration W-1.
  - DONE -> IDLE on out_valid && out_ready.
- Arbitration is round-robin with a last-grant pointer.
  - If both requesters are valid, grant the one not granted last.
  - If only one is valid, grant it.
  - The pointer resets to 1, so requester 0 wins the first contention.
  - The pointer updates only on acceptance.
- On acceptance:
  - req_ready[g] is high combinationally in IDLE for the granted g.
  - Operands and g are captured; acc is cleared.
  - Operands are not resampled after acceptance.
- No request is accepted in SUM, MUL or DONE; req_ready stays 0 in those states.
- A valid request must hold stable until its req_ready pulse.
- out_y, out_id and out_valid stay stable while out_valid && !out_ready.
- Reset values: state IDLE, req_ready 0, out_valid 0, out_y 0, out_id 0, busy 0, pointer 1, iteration counter 0.
- Reset asserted mid-operation aborts the computation immediately and asynchronously. The in-flight result is lost and all outputs take their reset values.

## Timing
- Acceptance is at the clock edge where IDLE && |req_valid. Call it edge T.
- Edge T+1: s registered; state becomes MUL.
- Edges T+2..T+9: iterations 0..7. At T+9 the state becomes DONE and out_valid rises.
- Latency is 9 cycles from acceptance to out_valid when W=8. In general it is W+1 cycles.
- If out_ready is high on the first out_valid cycle, the result is consumed at edge T+10 and the state returns to IDLE.
- The earliest next acceptance is edge T+11, giving a throughput of one result per W+3 cycles with no backpressure.
- busy is registered and equals state != IDLE.

## Structure
- Shared package arith_pkg holds:
  - FSM state enum: IDLE, SUM, MUL, DONE.
  - Default width constant, 8.
  - Requester count constant, 2.
- One sub-module: cla_adder_w, a W-bit carry-lookahead adder with inputs a, b, cin (tied 0) and outputs sum, cout. Exactly one instance exists.
- Adder operand muxing is selected by state:
  - SUM: operands x1 and x3.
  - MUL: operands acc and the gated shifted s.
- The round-robin arbiter stays inline.

## Test plan
- Requester 0 sends x1=4, x2=5, x3=2 with out_ready held high -> out_y=30 (0x1E), out_id=0, out_valid exactly 9 cycles after acceptance.
- Requester 1 sends x1=x2=x3=0 -> out_y=0, out_id=1.
- Wrap-around, requester 0:
  - x1=200, x2=3, x3=100: sum 300 wraps to 44, product 132 -> out_y=132.
  - x1=16, x2=17, x3=0: product 272 -> out_y=16.
- Both requesters valid from reset with distinct operands -> requester 0 is served first, then requester 1. A third contention grants requester 0 again. req_ready is never two-hot.
- out_ready held low for 5 cycles in DONE -> out_valid, out_y and out_id stay stable. No acceptance occurs during the hold. The result is consumed on the first cycle out_ready is high.
- rst asserted at cycle T+5 of an operation -> all outputs are 0 immediately. After release, a fresh request with 4, 5, 2 completes with out_y=30.
